control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit breadboard CPU. It sits directly upstream of the ALU and drives its `eo_`, `su` and `fi_` inputs. It consumes the ALU's `cf`/`zf` outputs into an internal flags register, which it uses for conditional jumps. It steps through fetch/execute T-states from the instruction register opcode and emits a 16-bit control word to every other datapath block.

---
 rtl/control_sequencer.sv | 124 ++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: T-state counter, flags register and combinational control word.
// Optional SEQ_EARLY_END_EN: an all-zero word at T2 or later ends the instruction early.
module control_sequencer #(
  parameter int OPW   = 4,
  parameter int NSTEP = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] ir,
  input  logic           cf,
  input  logic           zf,
  output logic [15:0]    ctl,
  output logic           eo_,
  output logic           su,
  output logic           fi_,
  output logic [2:0]     step,
  output logic           cf_q,
  output logic           zf_q
);

  localparam logic [2:0] LastStep = 3'(NSTEP - 1);

  localparam logic [15:0] WFetch0 = 16'h4004;
  localparam logic [15:0] WFetch1 = 16'h1408;
  localparam logic [15:0] WIoMi   = 16'h4800;
  localparam logic [15:0] WRoAi   = 16'h1200;
  localparam logic [15:0] WRoBi   = 16'h1020;
  localparam logic [15:0] WAdd    = 16'h0281;
  localparam logic [15:0] WSub    = 16'h02C1;
  localparam logic [15:0] WAoRi   = 16'h2100;
  localparam logic [15:0] WIoAi   = 16'h0A00;
  localparam logic [15:0] WJump   = 16'h0802;
  localparam logic [15:0] WOut    = 16'h0110;
  localparam logic [15:0] WHalt   = 16'h8000;

  logic [2:0] step_q, step_d;
  logic       cf_d, zf_d;
  logic [3:0] op;

  // Opcodes above 15 (only possible when OPW > 4) decode as NOP.
  always_comb begin
    op = 4'd0;
    if (32'(ir) < 32'd16) op = 4'(ir);
  end

  always_comb begin
    ctl = 16'h0000;
    unique case (step_q)
      3'd0: ctl = WFetch0;
      3'd1: ctl = WFetch1;
      3'd2: begin
        case (op)
          4'd1, 4'd2, 4'd3, 4'd4: ctl = WIoMi;
          4'd5:  ctl = WIoAi;
          4'd6:  ctl = WJump;
          4'd7:  ctl = cf_q ? WJump : 16'h0000;
          4'd8:  ctl = zf_q ? WJump : 16'h0000;
          4'd14: ctl = WOut;
          4'd15: ctl = WHalt;
          default: ctl = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'd1:       ctl = WRoAi;
          4'd2, 4'd3: ctl = WRoBi;
          4'd4:       ctl = WAoRi;
          default:    ctl = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'd2:    ctl = WAdd;
          4'd3:    ctl = WSub;
          default: ctl = 16'h0000;
        endcase
      end
      default: ctl = 16'h0000;
    endcase
  end

  assign eo_  = ~ctl[7];
  assign su   = ctl[6];
  assign fi_  = ~ctl[0];
  assign step = step_q;

  always_comb begin
    step_d = step_q;
    if (!ctl[15]) begin
`ifdef SEQ_EARLY_END_EN
      if (step_q >= 3'd2 && ctl == 16'h0000) begin
        step_d = 3'd0;
      end else
`endif
      if (step_q == LastStep) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_comb begin
    cf_d = cf_q;
    zf_d = zf_q;
    if (ctl[0]) begin
      cf_d = cf;
      zf_d = zf;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q <= 3'd0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      step_q <= step_d;
      cf_q   <= cf_d;
      zf_q   <= zf_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized traffic
// compared every cycle against an instruction-table reference model.
module tb_control_sequencer;

  localparam int OPW   = 4;
  localparam int NSTEP = 5;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [OPW-1:0] ir  = '0;
  logic           cf  = 1'b0;
  logic           zf  = 1'b0;
  logic [15:0]    ctl;
  logic           eo_, su, fi_;
  logic [2:0]     step;
  logic           cf_q, zf_q;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.OPW(OPW), .NSTEP(NSTEP)) dut (
    .clk  (clk),
    .clr  (clr),
    .ir   (ir),
    .cf   (cf),
    .zf   (zf),
    .ctl  (ctl),
    .eo_  (eo_),
    .su   (su),
    .fi_  (fi_),
    .step (step),
    .cf_q (cf_q),
    .zf_q (zf_q)
  );

  always #5 clk = ~clk;

  // Reference: per-opcode microprogram table, T0..T4.
  logic [15:0] prog [16][5];
  int  m_step;
  bit  m_cf, m_zf;

  function automatic logic [15:0] model_word(int t, int op, bit fc, bit fz);
    if (t >= 5) return 16'h0000;
    if (op == 7 && t == 2) return fc ? 16'h0802 : 16'h0000;
    if (op == 8 && t == 2) return fz ? 16'h0802 : 16'h0000;
    return prog[op][t];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [15:0] w;
    w = model_word(m_step, int'(ir), m_cf, m_zf);
    chk("ctl", ctl, w);
    chk("eo_", 16'(eo_), 16'(!w[7]));
    chk("su", 16'(su), 16'(w[6]));
    chk("fi_", 16'(fi_), 16'(!w[0]));
    chk("step", 16'(step), 16'(m_step));
    chk("cf_q", 16'(cf_q), 16'(m_cf));
    chk("zf_q", 16'(zf_q), 16'(m_zf));
  endtask

  // Called at a falling edge: apply inputs, predict the next rising edge, then compare.
  task automatic tick(input bit c, input int op, input bit fc, input bit fz);
    logic [15:0] w;
    clr = c;
    ir  = OPW'(op);
    cf  = fc;
    zf  = fz;
    w = model_word(m_step, op, m_cf, m_zf);
    if (c) begin
      m_step = 0;
      m_cf   = 0;
      m_zf   = 0;
    end else begin
      if (w[0]) begin
        m_cf = fc;
        m_zf = fz;
      end
      if (!w[15]) begin
`ifdef SEQ_EARLY_END_EN
        if (m_step >= 2 && w == 16'h0000) m_step = 0;
        else
`endif
        m_step = (m_step + 1) % NSTEP;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int o = 0; o < 16; o++) begin
      prog[o][0] = 16'h4004;
      prog[o][1] = 16'h1408;
      prog[o][2] = 16'h0000;
      prog[o][3] = 16'h0000;
      prog[o][4] = 16'h0000;
    end
    prog[1][2] = 16'h4800; prog[1][3] = 16'h1200;
    prog[2][2] = 16'h4800; prog[2][3] = 16'h1020; prog[2][4] = 16'h0281;
    prog[3][2] = 16'h4800; prog[3][3] = 16'h1020; prog[3][4] = 16'h02C1;
    prog[4][2] = 16'h4800; prog[4][3] = 16'h2100;
    prog[5][2] = 16'h0A00;
    prog[6][2] = 16'h0802;
    prog[14][2] = 16'h0110;
    prog[15][2] = 16'h8000;
    m_step = 0; m_cf = 0; m_zf = 0;

    // Reset state
    tick(1, 9, 1, 1);
    tick(1, 9, 1, 1);
    chk("rst step", 16'(step), 16'd0);
    chk("rst ctl", ctl, 16'h4004);
    chk("rst eo_", 16'(eo_), 16'd1);
    chk("rst fi_", 16'(fi_), 16'd1);
    chk("rst su", 16'(su), 16'd0);
    chk("rst flags", 16'({cf_q, zf_q}), 16'd0);

    // ADD with carry set
    tick(0, 2, 1, 0); chk("add t1", ctl, 16'h1408);
    tick(0, 2, 1, 0); chk("add t2", ctl, 16'h4800);
    tick(0, 2, 1, 0); chk("add t3", ctl, 16'h1020);
    tick(0, 2, 1, 0); chk("add t4", ctl, 16'h0281);
    chk("add t4 eo_", 16'(eo_), 16'd0);
    chk("add t4 fi_", 16'(fi_), 16'd0);
    tick(0, 2, 1, 0); chk("add end ctl", ctl, 16'h4004);
    chk("add flags", 16'({cf_q, zf_q}), 16'b10);

    // JC taken
    tick(0, 7, 1, 0);
    tick(0, 7, 1, 0); chk("jc taken", ctl, 16'h0802);
    tick(0, 7, 1, 0); chk("jc taken step", 16'(step), 16'd3);
    while (m_step != 0) tick(0, 7, 0, 0);

    // JC not taken
    tick(1, 7, 0, 0);
    tick(0, 7, 0, 0);
    tick(0, 7, 0, 0); chk("jc not taken", ctl, 16'h0000);
    tick(0, 7, 0, 0);
`ifdef SEQ_EARLY_END_EN
    chk("jc nt step", 16'(step), 16'd0);
`else
    chk("jc nt step", 16'(step), 16'd3);
    tick(0, 7, 0, 0); chk("jc nt step4", 16'(step), 16'd4);
    tick(0, 7, 0, 0); chk("jc nt step0", 16'(step), 16'd0);
`endif

    // HLT holds until reset
    tick(1, 15, 0, 0);
    tick(0, 15, 0, 0);
    tick(0, 15, 0, 0); chk("hlt ctl", ctl, 16'h8000);
    for (int i = 0; i < 12; i++) begin
      tick(0, 15, 1, 1);
      chk("hlt hold", 16'(step), 16'd2);
    end
    tick(1, 15, 0, 0);
    chk("hlt clr step", 16'(step), 16'd0);
    chk("hlt clr ctl", ctl, 16'h4004);

    // SUB sets carry, second SUB reset at T3
    tick(0, 3, 1, 0);
    repeat (4) tick(0, 3, 1, 0);
    chk("sub cf", 16'(cf_q), 16'd1);
    tick(0, 3, 0, 0);
    tick(0, 3, 0, 0);
    tick(0, 3, 0, 0); chk("sub t3", ctl, 16'h1020);
    tick(1, 3, 0, 0);
    chk("sub rst step", 16'(step), 16'd0);
    chk("sub rst cf", 16'(cf_q), 16'd0);
    chk("sub rst ctl", ctl, 16'h4004);

    // LDA never loads flags
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 1);
    chk("lda flags", 16'({cf_q, zf_q}), 16'd0);

    // Randomized traffic; opcode changes only at instruction boundaries
    begin
      int op;
      op = 0;
      for (int i = 0; i < 3000; i++) begin
        if (m_step == 0) op = int'($urandom_range(0, 15));
        tick(($urandom_range(0, 63) == 0), op, 1'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
